// File: rtl/commit_lockstep_if.sv
// Commit-channel bundle between the two commit sources and the lockstep controller.
// master drives commits and control; slave is the controller.
interface commit_lockstep_if #(
  parameter int CNT_W = 32
);
  logic             enable;
  logic             clear;
  logic             dut_valid;
  logic [296:0]     dut_pkt;
  logic             ref_valid;
  logic [296:0]     ref_pkt;
  logic             cmp_valid;
  logic             cmp_match;
  logic [8:0]       mismatch_mask;
  logic [63:0]      mismatch_pc;
  logic             err_mismatch;
  logic             err_overflow;
  logic             err_timeout;
  logic             halted;
  logic [CNT_W-1:0] match_count;

  modport master (
    output enable, clear, dut_valid, dut_pkt, ref_valid, ref_pkt,
    input  cmp_valid, cmp_match, mismatch_mask, mismatch_pc,
           err_mismatch, err_overflow, err_timeout, halted, match_count
  );

  modport slave (
    input  enable, clear, dut_valid, dut_pkt, ref_valid, ref_pkt,
    output cmp_valid, cmp_match, mismatch_mask, mismatch_pc,
           err_mismatch, err_overflow, err_timeout, halted, match_count
  );
endinterface

// File: rtl/commit_lockstep_ctrl.sv
// Lockstep commit comparator: buffers DUT and reference commits per side, pops matched
// pairs, compares them field by field and halts on divergence, overflow or lag timeout.
//
// state  | meaning
// S_IDLE | enable low; commits dropped, FIFO contents and timer held
// S_RUN  | commits accepted, pairs popped and compared
// S_HALT | error seen; frozen until clear
module commit_lockstep_ctrl #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input logic clk,
  input logic rst_n,
  commit_lockstep_if.slave cif
);

  localparam int PKT_W = 297;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0] PTR_ONE = 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  typedef struct packed {
    logic [1:0]  priv;
    logic        trap;
    logic [63:0] mem_wdata;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [63:0] rd_data;
    logic [4:0]  rd_addr;
    logic [31:0] instr;
    logic [63:0] pc;
  } commit_pkt_t;

  state_t state, state_nxt;

  logic [PKT_W-1:0] dut_mem [DEPTH];
  logic [PKT_W-1:0] ref_mem [DEPTH];
  logic [PTR_W:0]   dut_wp, dut_rp, ref_wp, ref_rp;
  logic [TMR_W-1:0] timer;

  logic             cmp_valid_q, cmp_match_q;
  logic [8:0]       mask_q;
  logic [63:0]      mis_pc_q;
  logic             err_mis_q, err_ovf_q, err_tmo_q;
  logic [CNT_W-1:0] match_cnt_q;

  logic dut_empty, ref_empty, dut_full, ref_full;
  logic run_act, pop, lag, tmo, mis_err, err_any;
  logic dut_push, ref_push, dut_ovf, ref_ovf;
  logic [8:0] miss;
  commit_pkt_t dh, rh;

  assign dut_empty = (dut_wp == dut_rp);
  assign ref_empty = (ref_wp == ref_rp);
  assign dut_full  = (dut_wp[PTR_W] != dut_rp[PTR_W]) &&
                     (dut_wp[PTR_W-1:0] == dut_rp[PTR_W-1:0]);
  assign ref_full  = (ref_wp[PTR_W] != ref_rp[PTR_W]) &&
                     (ref_wp[PTR_W-1:0] == ref_rp[PTR_W-1:0]);

  // clear wins over everything else in the same cycle
  assign run_act = (state == S_RUN) && cif.enable && !cif.clear;
  assign pop     = run_act && !dut_empty && !ref_empty;
  assign dut_ovf = run_act && cif.dut_valid && dut_full && !pop;
  assign ref_ovf = run_act && cif.ref_valid && ref_full && !pop;
  assign dut_push = run_act && cif.dut_valid && !dut_ovf;
  assign ref_push = run_act && cif.ref_valid && !ref_ovf;
  assign lag     = run_act && (dut_empty != ref_empty);
  assign tmo     = lag && (timer == TMR_LAST);

  assign dh = commit_pkt_t'(dut_mem[dut_rp[PTR_W-1:0]]);
  assign rh = commit_pkt_t'(ref_mem[ref_rp[PTR_W-1:0]]);

  always_comb begin
    miss    = '0;
    miss[0] = (dh.pc != rh.pc);
    miss[1] = (dh.instr != rh.instr);
    miss[2] = (dh.rd_addr != rh.rd_addr);
    miss[3] = (dh.rd_addr != 5'd0) && (dh.rd_data != rh.rd_data);
    miss[4] = (dh.mem_we != rh.mem_we);
    // memory payload only meaningful when both sides report a store
    miss[5] = dh.mem_we && rh.mem_we && (dh.mem_addr != rh.mem_addr);
    miss[6] = dh.mem_we && rh.mem_we && (dh.mem_wdata != rh.mem_wdata);
    miss[7] = (dh.trap != rh.trap);
    miss[8] = (dh.priv != rh.priv);
  end

  assign mis_err = pop && (miss != 9'd0);
  assign err_any = mis_err || dut_ovf || ref_ovf || tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cif.clear) begin
      state_nxt = cif.enable ? S_RUN : S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (cif.enable) state_nxt = S_RUN;
        S_RUN:   if (err_any) state_nxt = S_HALT;
                 else if (!cif.enable) state_nxt = S_IDLE;
        S_HALT:  state_nxt = S_HALT;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (dut_push) dut_mem[dut_wp[PTR_W-1:0]] <= cif.dut_pkt;
    if (ref_push) ref_mem[ref_wp[PTR_W-1:0]] <= cif.ref_pkt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_wp <= '0; dut_rp <= '0; ref_wp <= '0; ref_rp <= '0;
      timer <= '0;
      cmp_valid_q <= 1'b0; cmp_match_q <= 1'b0; mask_q <= '0; mis_pc_q <= '0;
      err_mis_q <= 1'b0; err_ovf_q <= 1'b0; err_tmo_q <= 1'b0;
      match_cnt_q <= '0;
    end else if (cif.clear) begin
      dut_wp <= '0; dut_rp <= '0; ref_wp <= '0; ref_rp <= '0;
      timer <= '0;
      cmp_valid_q <= 1'b0; cmp_match_q <= 1'b0; mask_q <= '0; mis_pc_q <= '0;
      err_mis_q <= 1'b0; err_ovf_q <= 1'b0; err_tmo_q <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      cmp_valid_q <= pop;
      if (pop) begin
        dut_rp      <= dut_rp + PTR_ONE;
        ref_rp      <= ref_rp + PTR_ONE;
        cmp_match_q <= (miss == 9'd0);
        mask_q      <= miss;
        if ((miss == 9'd0) && (match_cnt_q != '1)) match_cnt_q <= match_cnt_q + CNT_ONE;
      end
      if (mis_err && !err_mis_q) begin
        err_mis_q <= 1'b1;
        mis_pc_q  <= dh.pc;
      end
      if (dut_push) dut_wp <= dut_wp + PTR_ONE;
      if (ref_push) ref_wp <= ref_wp + PTR_ONE;
      if (dut_ovf || ref_ovf) err_ovf_q <= 1'b1;
      if (tmo) err_tmo_q <= 1'b1;
      if (run_act) timer <= lag ? timer + TMR_ONE : '0;
    end
  end

  assign cif.cmp_valid     = cmp_valid_q;
  assign cif.cmp_match     = cmp_match_q;
  assign cif.mismatch_mask = mask_q;
  assign cif.mismatch_pc   = mis_pc_q;
  assign cif.err_mismatch  = err_mis_q;
  assign cif.err_overflow  = err_ovf_q;
  assign cif.err_timeout   = err_tmo_q;
  assign cif.halted        = (state == S_HALT);
  assign cif.match_count   = match_cnt_q;

endmodule

// File: tb/tb_commit_lockstep_ctrl.sv
// Bench for commit_lockstep_ctrl: compare-rule vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based reference model.
module tb_commit_lockstep_ctrl;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  typedef struct packed {
    logic [1:0]  priv;
    logic        trap;
    logic [63:0] mem_wdata;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [63:0] rd_data;
    logic [4:0]  rd_addr;
    logic [31:0] instr;
    logic [63:0] pc;
  } pkt_t;

  typedef struct {
    string      name;
    int         rd;
    bit         we;
    int         fld;
    logic [8:0] exp_mask;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  commit_lockstep_if #(.CNT_W(CNT_W)) cif ();

  commit_lockstep_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cif(cif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  pkt_t q_d[$];
  pkt_t q_r[$];
  bit   m_run, m_halt;
  int   lag;
  bit   x_cv, x_cm, x_emis, x_eovf, x_etmo;
  logic [8:0]  x_mask;
  logic [63:0] x_pc;
  int   x_cnt;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pkt_t rand_pkt(int rd, bit we);
    pkt_t p;
    p.pc        = {$urandom(), $urandom()};
    p.instr     = $urandom();
    p.rd_addr   = rd[4:0];
    p.rd_data   = {$urandom(), $urandom()};
    p.mem_we    = we;
    p.mem_addr  = {$urandom(), $urandom()};
    p.mem_wdata = {$urandom(), $urandom()};
    p.trap      = 1'($urandom_range(0, 1));
    p.priv      = 2'($urandom_range(0, 3));
    return p;
  endfunction

  function automatic pkt_t flip(pkt_t p, int f);
    case (f)
      0: p.pc[0]        = ~p.pc[0];
      1: p.instr[0]     = ~p.instr[0];
      2: p.rd_addr[0]   = ~p.rd_addr[0];
      3: p.rd_data[0]   = ~p.rd_data[0];
      4: p.mem_we       = ~p.mem_we;
      5: p.mem_addr[0]  = ~p.mem_addr[0];
      6: p.mem_wdata[0] = ~p.mem_wdata[0];
      7: p.trap         = ~p.trap;
      8: p.priv[0]      = ~p.priv[0];
      default: ;
    endcase
    return p;
  endfunction

  // field-wise difference, restricted by the rd_addr/store qualification rules
  function automatic logic [8:0] ref_mask(pkt_t d, pkt_t r);
    logic [8:0] m;
    bit store;
    store = d.mem_we && r.mem_we;
    m = '0;
    if (d.pc != r.pc) m[0] = 1'b1;
    if (d.instr != r.instr) m[1] = 1'b1;
    if (d.rd_addr != r.rd_addr) m[2] = 1'b1;
    if (d.rd_addr != 0 && d.rd_data != r.rd_data) m[3] = 1'b1;
    if (d.mem_we != r.mem_we) m[4] = 1'b1;
    if (store && d.mem_addr != r.mem_addr) m[5] = 1'b1;
    if (store && d.mem_wdata != r.mem_wdata) m[6] = 1'b1;
    if (d.trap != r.trap) m[7] = 1'b1;
    if (d.priv != r.priv) m[8] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    q_d.delete(); q_r.delete();
    m_run = 0; m_halt = 0; lag = 0;
    x_cv = 0; x_cm = 0; x_mask = '0; x_pc = '0;
    x_emis = 0; x_eovf = 0; x_etmo = 0; x_cnt = 0;
  endtask

  task automatic model_step();
    if (cif.clear) begin
      model_reset();
      m_run = cif.enable;
      return;
    end
    x_cv = 0;
    if (m_run && !m_halt && cif.enable) begin
      int nd = q_d.size();
      int nr = q_r.size();
      bit popd = (nd > 0) && (nr > 0);
      bit err = 0;
      if (popd) begin
        pkt_t a = q_d.pop_front();
        pkt_t b = q_r.pop_front();
        logic [8:0] mk = ref_mask(a, b);
        x_cv = 1; x_mask = mk; x_cm = (mk == 0);
        if (mk == 0) begin
          if (x_cnt < (1 << CNT_W) - 1) x_cnt++;
        end else begin
          x_emis = 1; x_pc = a.pc; err = 1;
        end
      end
      if ((nd > 0) != (nr > 0)) begin
        lag++;
        if (lag >= TIMEOUT) begin x_etmo = 1; err = 1; end
      end else begin
        lag = 0;
      end
      if (cif.dut_valid) begin
        if (nd == DEPTH && !popd) begin x_eovf = 1; err = 1; end
        else q_d.push_back(pkt_t'(cif.dut_pkt));
      end
      if (cif.ref_valid) begin
        if (nr == DEPTH && !popd) begin x_eovf = 1; err = 1; end
        else q_r.push_back(pkt_t'(cif.ref_pkt));
      end
      if (err) m_halt = 1;
    end else if (!m_halt) begin
      m_run = cif.enable;
    end
  endtask

  task automatic check_model();
    check("cmp_valid", 64'(cif.cmp_valid), 64'(x_cv));
    check("cmp_match", 64'(cif.cmp_match), 64'(x_cm));
    check("mismatch_mask", 64'(cif.mismatch_mask), 64'(x_mask));
    check("mismatch_pc", cif.mismatch_pc, x_pc);
    check("err_mismatch", 64'(cif.err_mismatch), 64'(x_emis));
    check("err_overflow", 64'(cif.err_overflow), 64'(x_eovf));
    check("err_timeout", 64'(cif.err_timeout), 64'(x_etmo));
    check("halted", 64'(cif.halted), 64'(m_halt));
    check("match_count", 64'(cif.match_count), 64'(x_cnt));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    cif.clear = 0; cif.dut_valid = 0; cif.ref_valid = 0;
  endtask

  task automatic do_clear();
    cif.clear = 1; cif.dut_valid = 0; cif.ref_valid = 0;
    tick();
    cif.clear = 0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_cmp_valid"}, 64'(cif.cmp_valid), 64'd0);
    check({tag, "_cmp_match"}, 64'(cif.cmp_match), 64'd0);
    check({tag, "_mask"}, 64'(cif.mismatch_mask), 64'd0);
    check({tag, "_pc"}, cif.mismatch_pc, 64'd0);
    check({tag, "_errs"}, 64'({cif.err_mismatch, cif.err_overflow, cif.err_timeout}), 64'd0);
    check({tag, "_halted"}, 64'(cif.halted), 64'd0);
    check({tag, "_count"}, 64'(cif.match_count), 64'd0);
  endtask

  vec_t vecs[13];
  pkt_t seq[8];
  pkt_t pend[$];

  initial begin
    pkt_t p, r;
    int pulses, first;

    vecs[0]  = '{"identical",       3, 1'b1, -1, 9'h000};
    vecs[1]  = '{"pc_diff",         3, 1'b1,  0, 9'h001};
    vecs[2]  = '{"instr_diff",      3, 1'b1,  1, 9'h002};
    vecs[3]  = '{"rd_addr_diff",    3, 1'b1,  2, 9'h004};
    vecs[4]  = '{"rd_data_diff",    5, 1'b0,  3, 9'h008};
    vecs[5]  = '{"rd_data_x0",      0, 1'b1,  3, 9'h000};
    vecs[6]  = '{"we_diff",         7, 1'b1,  4, 9'h010};
    vecs[7]  = '{"addr_diff_st",    7, 1'b1,  5, 9'h020};
    vecs[8]  = '{"addr_diff_nost",  7, 1'b0,  5, 9'h000};
    vecs[9]  = '{"wdata_diff_st",   9, 1'b1,  6, 9'h040};
    vecs[10] = '{"wdata_diff_nost", 9, 1'b0,  6, 9'h000};
    vecs[11] = '{"trap_diff",       1, 1'b0,  7, 9'h080};
    vecs[12] = '{"priv_diff",       1, 1'b0,  8, 9'h100};

    cif.enable = 0; idle_inputs();
    cif.dut_pkt = '0; cif.ref_pkt = '0;
    model_reset();
    #3;
    check_all_zero("reset");
    #9 rst_n = 1;
    tick();
    cif.enable = 1;
    tick();

    // ten identical pairs back to back
    pulses = 0; first = -1;
    for (int i = 1; i <= 12; i++) begin
      if (i <= 10) begin
        p = rand_pkt($urandom_range(0, 31), 1'($urandom_range(0, 1)));
        cif.dut_valid = 1; cif.ref_valid = 1; cif.dut_pkt = p; cif.ref_pkt = p;
      end else begin
        idle_inputs();
      end
      tick();
      if (cif.cmp_valid) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    check("t1_pulses", 64'(pulses), 64'd10);
    check("t1_first_pulse", 64'(first), 64'd2);
    check("t1_match_count", 64'(cif.match_count), 64'd10);

    // DUT leads by three commits; count also saturates at 15
    for (int i = 0; i < 8; i++) seq[i] = rand_pkt($urandom_range(0, 31), 1'($urandom_range(0, 1)));
    for (int c = 0; c < 13; c++) begin
      idle_inputs();
      if (c < 8) begin cif.dut_valid = 1; cif.dut_pkt = seq[c]; end
      if (c >= 3 && c < 11) begin cif.ref_valid = 1; cif.ref_pkt = seq[c-3]; end
      tick();
    end
    check("t2_timeout", 64'(cif.err_timeout), 64'd0);
    check("t2_mismatch", 64'(cif.err_mismatch), 64'd0);
    check("t2_count_sat", 64'(cif.match_count), 64'd15);

    // compare-rule vectors
    foreach (vecs[k]) begin
      do_clear();
      p = rand_pkt(vecs[k].rd, vecs[k].we);
      r = flip(p, vecs[k].fld);
      cif.dut_valid = 1; cif.ref_valid = 1; cif.dut_pkt = p; cif.ref_pkt = r;
      tick();
      idle_inputs();
      tick();
      check({vecs[k].name, "_valid"}, 64'(cif.cmp_valid), 64'd1);
      check({vecs[k].name, "_mask"}, 64'(cif.mismatch_mask), 64'(vecs[k].exp_mask));
      check({vecs[k].name, "_match"}, 64'(cif.cmp_match), 64'(vecs[k].exp_mask == 0));
      check({vecs[k].name, "_halted"}, 64'(cif.halted), 64'(vecs[k].exp_mask != 0));
      check({vecs[k].name, "_pc"}, cif.mismatch_pc, (vecs[k].exp_mask != 0) ? p.pc : 64'd0);
    end

    // overflow: nine DUT pushes with reference idle
    do_clear();
    for (int i = 1; i <= 9; i++) begin
      cif.dut_valid = 1; cif.dut_pkt = rand_pkt(1, 1'b0);
      tick();
      if (i == 8) check("ovf_before", 64'(cif.err_overflow), 64'd0);
    end
    idle_inputs();
    check("ovf_flag", 64'(cif.err_overflow), 64'd1);
    check("ovf_halted", 64'(cif.halted), 64'd1);
    do_clear();
    check("ovf_clear_halted", 64'(cif.halted), 64'd0);
    check("ovf_clear_flag", 64'(cif.err_overflow), 64'd0);
    p = rand_pkt(4, 1'b1);
    cif.dut_valid = 1; cif.ref_valid = 1; cif.dut_pkt = p; cif.ref_pkt = p;
    tick();
    idle_inputs();
    tick();
    check("ovf_fresh_pair", 64'({cif.cmp_valid, cif.cmp_match}), 64'd3);

    // timeout: single DUT commit, reference silent
    do_clear();
    cif.dut_valid = 1; cif.dut_pkt = rand_pkt(2, 1'b0);
    tick();
    idle_inputs();
    for (int i = 1; i < TIMEOUT; i++) tick();
    check("tmo_before", 64'(cif.err_timeout), 64'd0);
    tick();
    check("tmo_flag", 64'(cif.err_timeout), 64'd1);
    check("tmo_halted", 64'(cif.halted), 64'd1);

    // randomized traffic
    do_clear();
    pend.delete();
    for (int c = 0; c < 1500; c++) begin
      idle_inputs();
      if (m_halt && $urandom_range(0, 3) == 0) begin
        cif.clear = 1;
        pend.delete();
      end
      cif.enable = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 1) == 1) begin
        p = rand_pkt($urandom_range(0, 31), 1'($urandom_range(0, 1)));
        cif.dut_valid = 1; cif.dut_pkt = p;
        pend.push_back(p);
      end
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        r = pend.pop_front();
        if ($urandom_range(0, 59) == 0) r = flip(r, $urandom_range(0, 8));
        cif.ref_valid = 1; cif.ref_pkt = r;
      end else if ($urandom_range(0, 79) == 0) begin
        cif.ref_valid = 1; cif.ref_pkt = rand_pkt($urandom_range(0, 31), 1'b1);
      end
      tick();
    end

    // asynchronous reset in the middle of traffic
    idle_inputs();
    cif.enable = 1;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      p = rand_pkt(6, 1'b1);
      cif.dut_valid = 1; cif.ref_valid = 1; cif.dut_pkt = p; cif.ref_pkt = p;
      tick();
    end
    #2 rst_n = 0;
    #1;
    check_all_zero("midreset");
    model_reset();
    idle_inputs();
    cif.enable = 0;
    #20 rst_n = 1;
    tick();
    check_all_zero("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
